// File: rtl/mem_cmd_stager.sv
// mem_cmd_stager: front end of the two-level (ready -> pending) memory command
// queue. Stamps accepted requests with the free-running cycle count, shadows
// the occupancy of both queue levels (the queue has no full flags) and runs a
// RUN -> DRAIN -> DRAINED quiesce sequence.
module mem_cmd_stager #(
  parameter int QUEUE_SIZE      = 16,
  parameter int REQ_SIZE        = 64,
  parameter int CYCLE_START_BIT = 0,
  parameter int CYCLE_END_BIT   = 31
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [REQ_SIZE-1:0] req_in,
  input  logic                drain_in,
  input  logic                issue_ready_in,
  input  logic                ready_empty_in,
  input  logic                pending_empty_in,
  input  logic                promote_in,
  output logic                enqueue_out,
  output logic [REQ_SIZE-1:0] req_out,
  output logic [31:0]         cycle_count_out,
  output logic                transfer_ready_out,
  output logic                promote_ready_out,
  output logic                drained_out,
  output logic                err_out
);

  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int TS_W  = CYCLE_END_BIT - CYCLE_START_BIT + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_SIZE);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t           state;
  logic [CNT_W-1:0] ready_cnt;
  logic [CNT_W-1:0] pending_cnt;
  logic [31:0]      cycle_cnt;
  logic             promote_fire;

  // Flow control is purely a function of registered state, so there is no
  // combinational path from any *_in handshake input back to req_ready_out.
  assign req_ready_out      = (state == RUN) && (ready_cnt < FULL);
  assign enqueue_out        = req_valid_in && req_ready_out;
  // No bypass: a full pending level blocks the transfer even if it is
  // promoting in the same cycle.
  assign transfer_ready_out = (ready_cnt != '0) && (pending_cnt < FULL);
  assign promote_ready_out  = issue_ready_in;
  assign promote_fire       = promote_in && issue_ready_in;
  assign cycle_count_out    = cycle_cnt;
  assign drained_out        = (state == DRAINED);

  // Overwrite the timestamp field of the request with the live cycle count.
  always_comb begin
    req_out = req_in;
    req_out[CYCLE_END_BIT:CYCLE_START_BIT] = cycle_cnt[TS_W-1:0];
  end

  // Free-running cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Shadow occupancy of both levels; simultaneous inc/dec cancel out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_cnt   <= '0;
      pending_cnt <= '0;
    end else begin
      case ({enqueue_out, transfer_ready_out})
        2'b10:   ready_cnt <= ready_cnt + 1'b1;
        2'b01:   ready_cnt <= ready_cnt - 1'b1;
        default: ready_cnt <= ready_cnt;
      endcase
      case ({transfer_ready_out, promote_fire})
        2'b10:   pending_cnt <= pending_cnt + 1'b1;
        2'b01:   pending_cnt <= pending_cnt - 1'b1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  // Sticky flag: shadow counts disagree with the queue's own empty flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) err_out <= 1'b0;
    else        err_out <= err_out
                           | ((ready_cnt == '0) ^ ready_empty_in)
                           | ((pending_cnt == '0) ^ pending_empty_in);
  end

  // Drain sequencer: intake stops outside RUN; transfers/promotes keep going.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (drain_in) state <= DRAIN;
        DRAIN:   if (!drain_in) state <= RUN;
                 else if (ready_cnt == '0 && pending_cnt == '0) state <= DRAINED;
        DRAINED: if (!drain_in) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_stager.sv
// Directed bench for mem_cmd_stager. A tiny queue model reacts to the
// stager's enqueue/transfer/promote controls to supply the empty flags and
// promote_in, the way the real two-level queue would.
module tb_mem_cmd_stager;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_in;
  logic        drain;
  logic        issue_ready;
  logic        ready_empty;
  logic        pending_empty;
  logic        promote;
  logic        enqueue;
  logic [63:0] req_out;
  logic [31:0] cycle_count;
  logic        transfer_ready;
  logic        promote_ready;
  logic        drained;
  logic        err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ready;
  int   m_pending;
  logic force_rdy_empty;
  logic prom_en;

  mem_cmd_stager #(
    .QUEUE_SIZE(16), .REQ_SIZE(64), .CYCLE_START_BIT(0), .CYCLE_END_BIT(31)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .req_valid_in      (req_valid),
    .req_ready_out     (req_ready),
    .req_in            (req_in),
    .drain_in          (drain),
    .issue_ready_in    (issue_ready),
    .ready_empty_in    (ready_empty),
    .pending_empty_in  (pending_empty),
    .promote_in        (promote),
    .enqueue_out       (enqueue),
    .req_out           (req_out),
    .cycle_count_out   (cycle_count),
    .transfer_ready_out(transfer_ready),
    .promote_ready_out (promote_ready),
    .drained_out       (drained),
    .err_out           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: occupancy follows the controls the stager drives.
  always @(posedge clk) begin
    if (rst) begin
      m_ready   <= 0;
      m_pending <= 0;
    end else begin
      m_ready   <= m_ready + int'(enqueue) - int'(transfer_ready);
      m_pending <= m_pending + int'(transfer_ready) - int'(promote && promote_ready);
    end
  end

  assign ready_empty   = force_rdy_empty ? 1'b1 : (m_ready == 0);
  assign pending_empty = (m_pending == 0);
  assign promote       = prom_en && (m_pending != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Leaves the bench at the negedge of the first post-reset cycle (count 0).
  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_in = '0; drain = 1'b0;
    issue_ready = 1'b0; prom_en = 1'b0; force_rdy_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (transfer_ready !== 1'b0) begin n_fail++; $display("FAIL reset_transfer: got %b want 0", transfer_ready); end
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained: got %b want 0", drained); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (enqueue !== 1'b0) begin n_fail++; $display("FAIL reset_enqueue: got %b want 0", enqueue); end
    @(negedge clk); #1;
    n_checks++; if (cycle_count !== 32'd1) begin n_fail++; $display("FAIL count_1: got %0d want 1", cycle_count); end
    @(negedge clk); #1;
    n_checks++; if (cycle_count !== 32'd2) begin n_fail++; $display("FAIL count_2: got %0d want 2", cycle_count); end
  endtask

  task automatic test_stamping();
    do_reset();
    repeat (5) @(negedge clk);
    req_valid = 1'b1; req_in = 64'hFFFF_FFFF_DEAD_BEEF;
    #1;
    n_checks++; if (req_out !== 64'hFFFF_FFFF_0000_0005) begin n_fail++; $display("FAIL stamp_5: got %h want ffffffff00000005", req_out); end
    n_checks++; if (enqueue !== 1'b1) begin n_fail++; $display("FAIL stamp_enqueue: got %b want 1", enqueue); end
    @(negedge clk);
    req_in = 64'h0123_4567_89AB_CDEF;
    #1;
    n_checks++; if (req_out !== 64'h0123_4567_0000_0006) begin n_fail++; $display("FAIL stamp_6: got %h want 0123456700000006", req_out); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (enqueue !== 1'b0) begin n_fail++; $display("FAIL stamp_idle_enqueue: got %b want 0", enqueue); end
  endtask

  // 33 back-to-back requests with pending held full (no promotes).
  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      req_valid = 1'b1;
      req_in = {16'hA5A5, 16'(i), 32'h0};
      #1;
      if (enqueue) acc++;
      if (i == 3) begin
        n_checks++; if (req_out !== {16'hA5A5, 16'd3, 32'd3}) begin n_fail++; $display("FAIL bp_stamp: got %h want a5a5000300000003", req_out); end
      end
      if (i == 16) begin
        n_checks++; if (transfer_ready !== 1'b1) begin n_fail++; $display("FAIL bp_xfer16: got %b want 1", transfer_ready); end
      end
      if (i == 17) begin
        n_checks++; if (transfer_ready !== 1'b0) begin n_fail++; $display("FAIL bp_xfer17: got %b want 0", transfer_ready); end
      end
      if (i == 31) begin
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready31: got %b want 1", req_ready); end
      end
      if (i == 32) begin
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready32: got %b want 0", req_ready); end
        n_checks++; if (enqueue !== 1'b0) begin n_fail++; $display("FAIL bp_enq33: got %b want 0", enqueue); end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++; if (acc != 32) begin n_fail++; $display("FAIL bp_accepted: got %0d want 32", acc); end
  endtask

  // Runs straight after backpressure: ready=16, pending=16.
  task automatic test_simultaneous();
    issue_ready = 1'b1; prom_en = 1'b1; req_valid = 1'b0;
    #1;
    n_checks++; if (transfer_ready !== 1'b0) begin n_fail++; $display("FAIL sim_xfer_full: got %b want 0", transfer_ready); end
    n_checks++; if (promote_ready !== 1'b1) begin n_fail++; $display("FAIL sim_promote_ready: got %b want 1", promote_ready); end
    @(negedge clk); #1;
    n_checks++; if (transfer_ready !== 1'b1) begin n_fail++; $display("FAIL sim_xfer_next: got %b want 1", transfer_ready); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sim_ready_full: got %b want 0", req_ready); end
    @(negedge clk);
    issue_ready = 1'b0; prom_en = 1'b0; req_valid = 1'b1;
    #1;
    n_checks++; if (enqueue !== 1'b1 || transfer_ready !== 1'b1) begin n_fail++; $display("FAIL sim_enq_xfer: got enq=%b xfer=%b want 1 1", enqueue, transfer_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (m_ready != 15 || m_pending != 16) begin n_fail++; $display("FAIL sim_occupancy: got %0d/%0d want 15/16", m_ready, m_pending); end
    n_checks++; if (transfer_ready !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sim_final: got xfer=%b ready=%b want 0 1", transfer_ready, req_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %b want 0", err); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_in = 64'(i);
      @(negedge clk);
    end
    req_valid = 1'b0; drain = 1'b1; issue_ready = 1'b1; prom_en = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b want 0", req_ready); end
    n_checks++; if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_early: got %b want 0", drained); end
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (drained !== 1'b0 || m_ready != 0 || m_pending != 0) begin n_fail++; $display("FAIL drain_empty: got drained=%b r=%0d p=%0d want 0 0 0", drained, m_ready, m_pending); end
    @(negedge clk); #1;
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_done: got %b want 1", drained); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL drained_ready: got %b want 0", req_ready); end
    @(negedge clk);
    drain = 1'b0;
    #1;
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_hold: got %b want 1", drained); end
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || drained !== 1'b0) begin n_fail++; $display("FAIL drain_resume: got ready=%b drained=%b want 1 0", req_ready, drained); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b want 0", err); end
  endtask

  task automatic test_drain_idle();
    do_reset();
    drain = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (drained !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_drain_c1: got drained=%b ready=%b want 0 0", drained, req_ready); end
    @(negedge clk); #1;
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL idle_drain_c2: got %b want 1", drained); end
    // Abort a drain that cannot finish (pending stuck without promotes).
    do_reset();
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; drain = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_draining: got %b want 0", req_ready); end
    drain = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || drained !== 1'b0) begin n_fail++; $display("FAIL abort_resume: got ready=%b drained=%b want 1 0", req_ready, drained); end
  endtask

  task automatic test_error();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req_valid = 1'b1; req_in = 64'(i);
      @(negedge clk);
    end
    req_valid = 1'b0; force_rdy_empty = 1'b1;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err); end
    @(negedge clk);
    force_rdy_empty = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL err_flow: got %b want 1", req_ready); end
    do_reset();
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
    n_checks++; if (transfer_ready !== 1'b0 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_midop: got xfer=%b count=%0d want 0 0", transfer_ready, cycle_count); end
  endtask

  initial begin
    test_reset();
    test_stamping();
    test_backpressure();
    test_simultaneous();
    test_drain();
    test_drain_idle();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_cmd_stager.md
Name: mem_cmd_stager

Overview:
- Front-end stage that feeds a two-level memory command queue (ready queue then pending queue).
- Accepts requests over a valid/ready handshake and stamps each with the current cycle count.
- Drives the queue's enqueue, ready-to-pending transfer and promote-ready controls.
- The queue exposes no full flags, so this block tracks occupancy of both levels itself; it also supports a drain/quiesce sequence.

Parameters:
- QUEUE_SIZE, 16, depth of each queue level; the two levels are identical.
- REQ_SIZE, 64, request vector width in bits.
- CYCLE_START_BIT, 0, LSB of the timestamp field inside the request.
- CYCLE_END_BIT, 31, MSB of the timestamp field; the field is at most 32 bits wide.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-high reset.
- req_valid_in  input  1  upstream request valid.
- req_ready_out  output  1  stager can accept a request.
- req_in  input  REQ_SIZE  upstream request; the timestamp field is ignored.
- drain_in  input  1  level-sensitive: stop accepting and empty both levels.
- issue_ready_in  input  1  command bus can take a promoted command.
- ready_empty_in  input  1  ready-queue empty flag from the queue.
- pending_empty_in  input  1  pending-queue empty flag from the queue.
- promote_in  input  1  queue's head-of-pending is eligible for promotion.
- enqueue_out  output  1  push into the ready queue.
- req_out  output  REQ_SIZE  stamped request to the queue.
- cycle_count_out  output  32  free-running cycle counter shared with the queue.
- transfer_ready_out  output  1  move the ready head into the pending queue.
- promote_ready_out  output  1  permit promotion this cycle.
- drained_out  output  1  both levels empty while in DRAINED state.
- err_out  output  1  sticky mismatch between tracked occupancy and queue empty flags.

Behaviour:
- **Reset.** All state updates on the rising clock edge. While rst_in is high:
  - cycle counter, ready_cnt and pending_cnt go to 0; state goes to RUN; err_out goes to 0.
  - In the cycle after reset: req_ready_out=1, enqueue_out=0, transfer_ready_out=0, drained_out=0, cycle_count_out=0.
  - Reset mid-operation discards all counts. The queue shares rst_in, so both sides clear together.
- **Cycle counter.** 32-bit, +1 every cycle, wraps 0xFFFFFFFF to 0.
- **Stamping.** req_out equals req_in with bits [CYCLE_END_BIT:CYCLE_START_BIT] replaced by the low (CYCLE_END_BIT-CYCLE_START_BIT+1) bits of cycle_count_out. This is combinational, with zero latency.
- **Occupancy counters.** ready_cnt and pending_cnt are each $clog2(QUEUE_SIZE+1) bits.
- **Accept path.**
  - req_ready_out = (state==RUN) && (ready_cnt < QUEUE_SIZE).
  - enqueue_out = req_valid_in && req_ready_out.
  - Both are combinational from registered state; there is no dependency on ready-in to valid-out.
- **Transfer path.**
  - transfer_ready_out = (ready_cnt != 0) && (pending_cnt < QUEUE_SIZE).
  - At most one transfer per cycle.
  - There is no bypass: if pending_cnt==QUEUE_SIZE, no transfer occurs even when a promote happens in the same cycle.
- **Promote path.**
  - promote_ready_out = issue_ready_in.
  - A promote fires when promote_in && issue_ready_in; this decrements pending_cnt.
- **Counter updates (next edge).**
  - ready_cnt += enqueue − transfer.
  - pending_cnt += transfer − promote.
  - Simultaneous increment and decrement leaves the count unchanged.
  - Neither counter ever underflows or overflows under the gating rules above.
- **Consistency check.**
  - Each cycle, compare (ready_cnt==0) with ready_empty_in, and (pending_cnt==0) with pending_empty_in.
  - Any mismatch sets err_out on the next edge.
  - err_out is cleared only by reset and does not alter flow control.
- **State machine.**
  - RUN: if drain_in, go to DRAIN.
  - DRAIN: req_ready_out=0; transfers and promotes continue. When ready_cnt==0 and pending_cnt==0, go to DRAINED. If drain_in drops, return to RUN.
  - DRAINED: drained_out=1 and req_ready_out=0. When drain_in drops, return to RUN.
  - drain_in asserted with both counts already 0: RUN → DRAIN → DRAINED on consecutive edges, so drained_out rises 2 cycles after drain_in.

Test Plan:
1. **Reset values.** Assert rst_in for 2 cycles, then release → cycle_count_out=0 then 1, 2, …; req_ready_out=1; transfer_ready_out=0; drained_out=0; err_out=0.
2. **Stamping.** With CYCLE field [31:0], req_in=64'hFFFF_FFFF_DEAD_BEEF presented at cycle_count_out=5 → req_out=64'hFFFF_FFFF_0000_0005 and enqueue_out=1.
3. **Backpressure.** Hold pending full by keeping issue_ready_in=0, and push 32 requests back-to-back → after 16 transfers, transfer_ready_out=0; after 16 more enqueues, req_ready_out=0; the 33rd request is not accepted.
4. **Simultaneous events.** ready_cnt=16, pending_cnt=16, then promote_in=1 and issue_ready_in=1 for one cycle → pending_cnt=15, transfer_ready_out stays 0 that cycle and is 1 the next cycle; in the following cycle an enqueue plus transfer leaves ready_cnt at 15.
5. **Drain.** 3 requests outstanding, drain_in=1, issue_ready_in=1 with promote_in following the queue → req_ready_out=0 immediately; drained_out=1 one cycle after both counts reach 0; deasserting drain_in restores req_ready_out=1.
6. **Error flag.** Force ready_empty_in=1 while ready_cnt=2 → err_out=1 on the next edge and stays 1; only rst_in clears it.
